// File: rtl/neuron_par_if.sv
// Bus bundle for neuron_par: config writes, input beats and result handshake.
interface neuron_par_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned DW    = 16
);
  logic                  cfg_valid;
  logic                  cfg_is_bias;
  logic [31:0]           cfg_layer;
  logic [31:0]           cfg_neuron;
  logic [31:0]           cfg_data;
  logic [LANES*DW-1:0]   in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DW-1:0]         out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output cfg_valid, cfg_is_bias, cfg_layer, cfg_neuron, cfg_data,
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  cfg_valid, cfg_is_bias, cfg_layer, cfg_neuron, cfg_data,
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/neuron_par.sv
// Multi-lane fully-connected neuron: LANES MACs per beat against a runtime-loaded
// weight RAM, saturating accumulate, bias add, ReLU and fixed-point rescale.
// Optional feature: define NEURON_ROUND_EN for round-half-up before the rescale
// shift; the default build truncates (floor).
module neuron_par #(
  parameter int unsigned LAYER_NO   = 0,
  parameter int unsigned NEURON_NO  = 0,
  parameter int unsigned NUM_WEIGHT = 784,
  parameter int unsigned LANES      = 4,
  parameter int unsigned DW         = 16,
  parameter int unsigned FRAC       = 8
) (
  input  logic         clk,
  input  logic         rst,
  neuron_par_if.slave  bus
);

  localparam int unsigned DEPTH = NUM_WEIGHT / LANES;
  localparam int unsigned AW    = 2 * DW;
  localparam int unsigned TW    = AW + $clog2(LANES);
  localparam int unsigned SW    = TW + 1;
  localparam int unsigned BW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LNW   = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic signed [SW-1:0] ACC_MAX = SW'({1'b0, {(AW-1){1'b1}}});
  localparam logic signed [SW-1:0] ACC_MIN = ~ACC_MAX;
  localparam logic signed [AW-1:0] OUT_MAX = AW'({1'b0, {(DW-1){1'b1}}});
`ifdef NEURON_ROUND_EN
  localparam logic signed [AW-1:0] RND = (FRAC > 0) ? AW'(1) << ((FRAC > 0) ? FRAC - 1 : 0) : '0;
`endif

  typedef enum logic [2:0] {S_ACC, S_DRAIN, S_BIAS, S_ACT, S_OUT} state_t;

  // Clamp a widened sum into the accumulator range.
  function automatic logic signed [AW-1:0] sat_acc(input logic signed [SW-1:0] x);
    if (x > ACC_MAX)      return ACC_MAX[AW-1:0];
    else if (x < ACC_MIN) return ACC_MIN[AW-1:0];
    else                  return x[AW-1:0];
  endfunction

  state_t                 state_q, state_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [1:0]             drain_q, drain_d;
  logic [BW-1:0]          wword_q, wword_d;
  logic [LNW-1:0]         wlane_q, wlane_d;
  logic signed [AW-1:0]   bias_q, bias_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [DW-1:0]          out_data_q, out_data_d;

  // Pipeline: stage 1 (RAM read + input capture), stage 2 (products)
  logic                   v1_q, v1_d;
  logic [LANES*DW-1:0]    x_q, x_d;
  logic [LANES*DW-1:0]    w_q, w_d;
  logic                   v2_q, v2_d;
  logic signed [AW-1:0]   prod_q [LANES];
  logic signed [AW-1:0]   prod_d [LANES];

  logic [LANES*DW-1:0]    ram_q [DEPTH];

  logic                   accept_c;
  logic                   cfg_hit_c;
  logic                   out_hs_c;
  logic signed [TW-1:0]   tree_c;
  logic [DW-1:0]          act_c;

  assign accept_c  = bus.in_valid && in_ready_q;
  assign out_hs_c  = out_valid_q && bus.out_ready;
  assign cfg_hit_c = bus.cfg_valid && (bus.cfg_layer == 32'(LAYER_NO)) &&
                     (bus.cfg_neuron == 32'(NEURON_NO));

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  generate
    if (DW < 32) begin : g_cfg_hi
      logic unused_cfg_hi;
      assign unused_cfg_hi = ^bus.cfg_data[31:DW];
    end
  endgenerate

  // Weight RAM: serial lane-by-lane writes, no reset on contents.
  always_ff @(posedge clk) begin
    if (cfg_hit_c && !bus.cfg_is_bias) begin
      ram_q[wword_q][wlane_q*DW +: DW] <= bus.cfg_data[DW-1:0];
    end
  end

  // Per-lane products of the captured beat.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      logic signed [DW-1:0] xs;
      logic signed [DW-1:0] ws;
      xs        = x_q[k*DW +: DW];
      ws        = w_q[k*DW +: DW];
      prod_d[k] = AW'(xs) * AW'(ws);
    end
  end

  // Adder tree over the registered products.
  always_comb begin
    tree_c = '0;
    for (int k = 0; k < LANES; k++) begin
      tree_c = tree_c + TW'(prod_q[k]);
    end
  end

  // ReLU, optional rounding, rescale and clamp to the non-negative output range.
  always_comb begin
    logic signed [AW-1:0] pos;
    logic signed [AW-1:0] shifted;
    pos = acc_q[AW-1] ? '0 : acc_q;
`ifdef NEURON_ROUND_EN
    pos = sat_acc(SW'(pos) + SW'(RND));
`endif
    shifted = pos >>> FRAC;
    if (shifted > OUT_MAX) act_c = OUT_MAX[DW-1:0];
    else                   act_c = shifted[DW-1:0];
  end

  // Next-state: FSM, pipeline, accumulator and config registers.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    drain_d     = drain_q;
    wword_d     = wword_q;
    wlane_d     = wlane_q;
    bias_d      = bias_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    v1_d        = accept_c;
    x_d         = x_q;
    w_d         = w_q;
    v2_d        = v1_q;

    if (accept_c) begin
      x_d = bus.in_data;
      w_d = ram_q[beat_q];
    end

    if (v2_q) begin
      acc_d = sat_acc(SW'(acc_q) + SW'(tree_c));
    end

    if (cfg_hit_c) begin
      if (bus.cfg_is_bias) begin
        bias_d = AW'($signed(bus.cfg_data[DW-1:0])) <<< FRAC;
      end else if (wlane_q == LNW'(LANES - 1)) begin
        wlane_d = '0;
        wword_d = (wword_q == BW'(DEPTH - 1)) ? '0 : wword_q + BW'(1);
      end else begin
        wlane_d = wlane_q + LNW'(1);
      end
    end

    case (state_q)
      S_ACC: begin
        if (accept_c) begin
          if (beat_q == BW'(DEPTH - 1)) begin
            beat_d  = '0;
            drain_d = '0;
            state_d = S_DRAIN;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == 2'd2) state_d = S_BIAS;
        else                 drain_d = drain_q + 2'd1;
      end
      S_BIAS: begin
        acc_d   = sat_acc(SW'(acc_q) + SW'(bias_q));
        state_d = S_ACT;
      end
      S_ACT: begin
        out_data_d  = act_c;
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_hs_c) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          state_d     = S_ACC;
        end
      end
      default: state_d = S_ACC;
    endcase

    in_ready_d = (state_d == S_ACC);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ACC;
      beat_q      <= '0;
      drain_q     <= '0;
      wword_q     <= '0;
      wlane_q     <= '0;
      bias_q      <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      v1_q        <= 1'b0;
      x_q         <= '0;
      w_q         <= '0;
      v2_q        <= 1'b0;
      for (int k = 0; k < LANES; k++) prod_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      drain_q     <= drain_d;
      wword_q     <= wword_d;
      wlane_q     <= wlane_d;
      bias_q      <= bias_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      v1_q        <= v1_d;
      x_q         <= x_d;
      w_q         <= w_d;
      v2_q        <= v2_d;
      for (int k = 0; k < LANES; k++) prod_q[k] <= prod_d[k];
    end
  end

endmodule
